udp_tx_frame_scheduler: RTL and testbench
=========================================

// Module: udp_tx_frame_scheduler
// PURPOSE
//  Shares one UDP TX port (data FIFO + status FIFO pair on the user side of udp_core8) among NUM_REQ frame sources.
//  Arbitration is round-robin. A frame is granted only when the data FIFO has room for the whole frame.
//  The grant then streams the payload bytes and writes the 96-bit status word {port,mac,ip} once, after the last byte.
//  Runs in the wrclk_udp_txfifo_N domain.
// PARAMETERS
//  NUM_REQ     4     number of frame sources (2..8)
//  LEN_W       11    width of frame length field
//  MAX_LEN     1472  largest legal payload length in bytes
//  DATA_DEPTH  8192  data FIFO depth in words (wrusedw is 13 bits)
//  SETTLE_CYC  3     idle cycles after a status write, so wrusedw can catch up
// PORTS
//  clock             in   1            user-side FIFO write clock
//  reset_n           in   1            synchronous reset, active low
//  req_valid         in   NUM_REQ      source i has a frame pending; held until req_ack[i]
//  req_len           in   NUM_REQ*LEN_W  payload length of source i, slice i
//  req_status        in   NUM_REQ*96   status word of source i, slice i
//  req_ack           out  NUM_REQ      1-cycle pulse: frame accepted (or rejected, see req_err)
//  req_err           out  1            valid together with req_ack: frame rejected, bad length
//  src_data          in   NUM_REQ*8    payload byte of source i
//  src_valid         in   NUM_REQ      payload byte valid
//  src_ready         out  NUM_REQ      byte consumed when src_valid&src_ready
//  wrreq_data        out  1            data FIFO write strobe
//  data_to_fifo      out  8            data FIFO write data
//  wrfull_data       in   1            data FIFO full
//  wrusedw_data      in   13           data FIFO words used
//  wrreq_status      out  1            status FIFO write strobe
//  status_to_fifo    out  96           status FIFO write data
//  wrfull_status     in   1            status FIFO full
//  busy              out  1            state != IDLE
//  grant_idx         out  3            index of the current/last granted source
//  frame_count       out  32           frames completed, wraps modulo 2^32
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge):
//   - state=IDLE; every output 0; last_grant=NUM_REQ-1; counters 0.
//   - Reset mid-frame abandons the frame. The system clears the TX FIFOs on the same reset.
//  IDLE:
//   - Pick the first i with req_valid[i], searching last_grant+1 ... wrapping. Latch i, len and status; go CHECK.
//   - No request: stay in IDLE.
//  CHECK:
//   - If the latched req_valid has dropped: go IDLE, no ack.
//   - If len==0 or len>MAX_LEN: pulse req_ack[i] with req_err=1, set last_grant=i, go IDLE.
//   - If {1'b0,wrusedw_data}+len < DATA_DEPTH (14-bit compare) and !wrfull_status: pulse req_ack[i], load cnt=len, go STREAM.
//   - Otherwise hold in CHECK. There is no re-arbitration while holding, so the granted source is never starved.
//  STREAM:
//   - src_ready[i] = !wrfull_data. All other src_ready are 0.
//   - wrreq_data = src_valid[i] & src_ready[i]; data_to_fifo = src_data[i]. Zero-latency pass-through.
//   - Each write decrements cnt. When the write with cnt==1 occurs, go STATUS.
//   - Bubbles on src_valid are allowed; the state holds.
//  STATUS:
//   - One cycle: wrreq_status=1, status_to_fifo = latched status (wrfull_status was checked in CHECK).
//   - Increment frame_count, set last_grant=i, go SETTLE.
//  SETTLE:
//   - Wait SETTLE_CYC cycles, then go IDLE. A new grant is possible on the next cycle.
//  General:
//   - req_ack is asserted only in CHECK and is exactly 1 cycle.
//   - The status write always follows the data of its own frame; frames never interleave.
//   - grant_idx updates when a source is latched in IDLE.
// TESTING
//  1. Source 0 frame len=4, bytes 11..14, FIFO empty.
//     -> ack in CHECK; 4 wrreq_data writes, bytes 11..14; 1 wrreq_status with the latched word; frame_count=1.
//  2. All 4 sources valid at once, len=2 each.
//     -> grant order 0,1,2,3. After a second set of requests from sources 1 and 3: order 1,3.
//  3. wrusedw_data=8190, len=2 -> holds in CHECK; no ack, no writes.
//     Drop wrusedw_data to 8189 -> ack next cycle, 2 writes.
//  4. len=0 and len=1473 -> req_ack with req_err=1, no FIFO writes, frame_count unchanged.
//  5. During STREAM, toggle src_valid and force wrfull_data=1 for 5 cycles
//     -> src_ready=0 and no writes while full; byte order intact; exactly len writes in total.
//  6. Assert reset_n=0 after byte 2 of a 10-byte frame
//     -> all outputs 0 next cycle; state IDLE; a new frame starts cleanly after reset is released.

Source files
------------

// File: rtl/udp_tx_frame_scheduler.sv
// Round-robin scheduler sharing one UDP TX data/status FIFO pair among NUM_REQ frame sources.
// A frame is granted only when the data FIFO can hold all of it; its status word follows the last byte.
module udp_tx_frame_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned MAX_LEN    = 1472,
    parameter int unsigned DATA_DEPTH = 8192,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*96-1:0]    req_status,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     req_err,
    input  logic [NUM_REQ*8-1:0]     src_data,
    input  logic [NUM_REQ-1:0]       src_valid,
    output logic [NUM_REQ-1:0]       src_ready,
    output logic                     wrreq_data,
    output logic [7:0]               data_to_fifo,
    input  logic                     wrfull_data,
    input  logic [12:0]              wrusedw_data,
    output logic                     wrreq_status,
    output logic [95:0]              status_to_fifo,
    input  logic                     wrfull_status,
    output logic                     busy,
    output logic [2:0]               grant_idx,
    output logic [31:0]              frame_count
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StCheck, StStream, StStatus, StSettle} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [95:0]       status_q, status_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [31:0]       count_q, count_d;

    logic              hi_found, lo_found;
    logic [IdxW-1:0]   hi_pick, lo_pick, pick;
    logic [NUM_REQ-1:0] sel_mask;
    logic              sel_valid, sel_src_valid;
    logic [7:0]        sel_src_data;
    logic [LEN_W-1:0]  pick_len;
    logic [95:0]       pick_status;
    logic [13:0]       room_sum;
    logic              len_bad, room_ok;

    // Lowest requester above last_q wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_pick  = IdxW'(i);
                if (i > int'(last_q)) begin
                    hi_found = 1'b1;
                    hi_pick  = IdxW'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        sel_mask      = '0;
        sel_valid     = 1'b0;
        sel_src_valid = 1'b0;
        sel_src_data  = '0;
        pick_len      = '0;
        pick_status   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_mask[i]   = 1'b1;
                sel_valid     = req_valid[i];
                sel_src_valid = src_valid[i];
                sel_src_data  = src_data[i*8 +: 8];
            end
            if (pick == IdxW'(i)) begin
                pick_len    = req_len[i*LEN_W +: LEN_W];
                pick_status = req_status[i*96 +: 96];
            end
        end
    end

    assign room_sum = {1'b0, wrusedw_data} + 14'(len_q);
    assign room_ok  = (room_sum < 14'(DATA_DEPTH)) && !wrfull_status;
    assign len_bad  = (len_q == '0) || (32'(len_q) > MAX_LEN);

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        idx_d          = idx_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        status_d       = status_q;
        settle_d       = settle_q;
        count_d        = count_q;
        req_ack        = '0;
        req_err        = 1'b0;
        src_ready      = '0;
        wrreq_data     = 1'b0;
        data_to_fifo   = '0;
        wrreq_status   = 1'b0;
        status_to_fifo = '0;
        unique case (state_q)
            StIdle: begin
                if (lo_found) begin
                    idx_d    = pick;
                    len_d    = pick_len;
                    status_d = pick_status;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!sel_valid) begin
                    state_d = StIdle;
                end else if (len_bad) begin
                    req_ack = sel_mask;
                    req_err = 1'b1;
                    last_d  = idx_q;
                    state_d = StIdle;
                end else if (room_ok) begin
                    req_ack = sel_mask;
                    cnt_d   = len_q;
                    state_d = StStream;
                end
            end
            StStream: begin
                src_ready    = sel_mask & {NUM_REQ{!wrfull_data}};
                wrreq_data   = sel_src_valid & !wrfull_data;
                data_to_fifo = sel_src_data;
                if (wrreq_data) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StStatus;
                    end
                end
            end
            StStatus: begin
                wrreq_status   = 1'b1;
                status_to_fifo = status_q;
                count_d        = count_q + 32'd1;
                last_d         = idx_q;
                settle_d       = '0;
                state_d        = StSettle;
            end
            StSettle: begin
                // Gives the FIFO's wrusedw time to reflect this frame before the next room check.
                if (settle_q == SetW'(SETTLE_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(NUM_REQ - 1);
            idx_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            settle_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            settle_q <= settle_d;
            count_q  <= count_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign grant_idx   = 3'(idx_q);
    assign frame_count = count_q;

endmodule

// File: tb/tb_udp_tx_frame_scheduler.sv
// Randomized bench for udp_tx_frame_scheduler: source drivers, FIFO-side monitor and a
// round-robin grant-order reference model.
module tb_udp_tx_frame_scheduler;

    localparam int N  = 4;
    localparam int LW = 11;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [N*96-1:0] req_status;
    logic [N-1:0]    req_ack;
    logic            req_err;
    logic [N*8-1:0]  src_data;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic            wrreq_data;
    logic [7:0]      data_to_fifo;
    logic            wrfull_data;
    logic [12:0]     wrusedw_data;
    logic            wrreq_status;
    logic [95:0]     status_to_fifo;
    logic            wrfull_status;
    logic            busy;
    logic [2:0]      grant_idx;
    logic [31:0]     frame_count;

    always #5 clock = ~clock;

    udp_tx_frame_scheduler dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_status     (req_status),
        .req_ack        (req_ack),
        .req_err        (req_err),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .wrreq_data     (wrreq_data),
        .data_to_fifo   (data_to_fifo),
        .wrfull_data    (wrfull_data),
        .wrusedw_data   (wrusedw_data),
        .wrreq_status   (wrreq_status),
        .status_to_fifo (status_to_fifo),
        .wrfull_status  (wrfull_status),
        .busy           (busy),
        .grant_idx      (grant_idx),
        .frame_count    (frame_count)
    );

    int          vecs;
    int          errs;
    int          cyc;

    // Source-side frame contents and read pointers.
    logic [7:0]  mem [N][2048];
    int          src_len [N];
    int          rd [N];
    int          b_len [N];
    logic [95:0] b_stat [N];
    bit          bubbles, full_rand, used_rand;

    // Reference model state.
    int          model_last;
    logic [31:0] model_count;

    // Monitor logs.
    int          ack_idx_q[$];
    bit          ack_err_q[$];
    int          ack_cyc_q[$];
    logic [7:0]  data_log[$];
    logic [95:0] stat_log[$];
    int          stat_cyc_q[$];

    task automatic clear_logs();
        ack_idx_q.delete();
        ack_err_q.delete();
        ack_cyc_q.delete();
        data_log.delete();
        stat_log.delete();
        stat_cyc_q.delete();
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < src_len[i] && (!bubbles || ($urandom % 3) != 0)) begin
                src_valid[i]       = 1'b1;
                src_data[i*8 +: 8] = mem[i][rd[i]];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[i*8 +: 8] = 8'($urandom);
            end
        end
    endtask

    // One clock: monitor at negedge, source/FIFO drivers just after posedge.
    task automatic tick();
        logic [N-1:0] fire, acked;
        @(negedge clock);
        cyc++;
        fire  = src_valid & src_ready;
        acked = req_ack;
        vecs++;
        if ($countones(src_ready) > 1 || (wrfull_data && src_ready != '0)) begin
            errs++;
            $display("FAIL src_ready cyc %0d: got %b with wrfull_data=%0b, want at most one bit and none when full",
                     cyc, src_ready, wrfull_data);
        end
        vecs++;
        if (wrreq_data !== (|fire)) begin
            errs++;
            $display("FAIL wrreq_data cyc %0d: got %0b, want %0b", cyc, wrreq_data, |fire);
        end
        vecs++;
        if ((req_ack != '0 && !$onehot(req_ack)) || (req_err && req_ack == '0)) begin
            errs++;
            $display("FAIL ack_shape cyc %0d: got ack %b err %0b, want one-hot ack with err", cyc,
                     req_ack, req_err);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                ack_idx_q.push_back(i);
                ack_err_q.push_back(req_err);
                ack_cyc_q.push_back(cyc);
            end
        end
        if (wrreq_data) data_log.push_back(data_to_fifo);
        if (wrreq_status) begin
            stat_log.push_back(status_to_fifo);
            stat_cyc_q.push_back(cyc);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) rd[i]++;
            if (acked[i]) req_valid[i] = 1'b0;
        end
        drive_src();
        if (full_rand) wrfull_data = (($urandom % 4) == 0);
        if (used_rand) begin
            wrusedw_data = (($urandom % 3) == 0) ? 13'(8180 + $urandom % 12) : 13'($urandom % 100);
        end
    endtask

    task automatic post(input int i, input int len);
        bit bad;
        bad       = (len == 0) || (len > 1472);
        b_len[i]  = len;
        b_stat[i] = {$urandom, $urandom, $urandom};
        req_len[i*LW +: LW]   = LW'(len);
        req_status[i*96 +: 96] = b_stat[i];
        src_len[i] = bad ? 0 : len;
        rd[i]      = 0;
        for (int k = 0; k < src_len[i]; k++) mem[i][k] = 8'($urandom);
        req_valid[i] = 1'b1;
        drive_src();
    endtask

    // Reference: round-robin from the last grant over the posted set, one frame at a time.
    task automatic run_batch(input string name, input logic [N-1:0] mask);
        int          exp_idx[$];
        bit          exp_err[$];
        logic [7:0]  exp_data[$];
        logic [95:0] exp_stat[$];
        logic [N-1:0] pend;
        int          t, first_diff;
        pend = mask;
        while (pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (model_last + k) % N;
                if (pend[c]) begin
                    bit bad;
                    bad = (b_len[c] == 0) || (b_len[c] > 1472);
                    exp_idx.push_back(c);
                    exp_err.push_back(bad);
                    if (!bad) begin
                        for (int b = 0; b < b_len[c]; b++) exp_data.push_back(mem[c][b]);
                        exp_stat.push_back(b_stat[c]);
                        model_count++;
                    end
                    pend[c]    = 1'b0;
                    model_last = c;
                    break;
                end
            end
        end
        t = 0;
        do begin
            tick();
            t++;
        end while (!(req_valid == '0 && !busy) && t < 6000);
        vecs++;
        if (t >= 6000) begin
            errs++;
            $display("FAIL %s timeout: got req_valid %b busy %0b after %0d cycles, want idle", name,
                     req_valid, busy, t);
        end
        vecs++;
        if (ack_idx_q.size() != exp_idx.size()) begin
            errs++;
            $display("FAIL %s ack_count: got %0d, want %0d", name, ack_idx_q.size(), exp_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < ack_idx_q.size(); k++) begin
            vecs++;
            if (ack_idx_q[k] != exp_idx[k] || ack_err_q[k] != exp_err[k]) begin
                errs++;
                $display("FAIL %s ack[%0d]: got src %0d err %0b, want src %0d err %0b", name, k,
                         ack_idx_q[k], ack_err_q[k], exp_idx[k], exp_err[k]);
            end
        end
        first_diff = -1;
        for (int k = 0; k < exp_data.size() && k < data_log.size(); k++) begin
            if (first_diff < 0 && data_log[k] !== exp_data[k]) first_diff = k;
        end
        vecs++;
        if (data_log.size() != exp_data.size() || first_diff >= 0) begin
            errs++;
            $display("FAIL %s data: got %0d bytes (first diff at %0d), want %0d bytes", name,
                     data_log.size(), first_diff, exp_data.size());
        end
        vecs++;
        if (stat_log.size() != exp_stat.size()) begin
            errs++;
            $display("FAIL %s status_count: got %0d, want %0d", name, stat_log.size(), exp_stat.size());
        end
        for (int k = 0; k < exp_stat.size() && k < stat_log.size(); k++) begin
            vecs++;
            if (stat_log[k] !== exp_stat[k]) begin
                errs++;
                $display("FAIL %s status[%0d]: got %h, want %h", name, k, stat_log[k], exp_stat[k]);
            end
        end
        vecs++;
        if (frame_count !== model_count) begin
            errs++;
            $display("FAIL %s frame_count: got %0d, want %0d", name, frame_count, model_count);
        end
        vecs++;
        if (grant_idx !== 3'(model_last)) begin
            errs++;
            $display("FAIL %s grant_idx: got %0d, want %0d", name, grant_idx, model_last);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        vecs++;
        if ({req_ack, req_err, src_ready, wrreq_data, data_to_fifo, wrreq_status, status_to_fifo,
             busy, grant_idx, frame_count} !== '0) begin
            errs++;
            $display("FAIL %s outputs: got ack %b rdy %b wrd %0b wrs %0b busy %0b gi %0d fc %0d, want all 0",
                     name, req_ack, src_ready, wrreq_data, wrreq_status, busy, grant_idx, frame_count);
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        full_rand = 1'b0;
        used_rand = 1'b0;
        bubbles   = 1'b0;
        req_valid = '0;
        wrfull_data = 1'b0;
        wrfull_status = 1'b0;
        wrusedw_data = '0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            rd[i]      = 0;
        end
        drive_src();
        tick();
        check_outputs_zero("reset");
        tick();
        reset_n     = 1'b1;
        model_last  = N - 1;
        model_count = '0;
        clear_logs();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        clear_logs();
        post(0, 4);
        for (int k = 0; k < 4; k++) mem[0][k] = 8'(11 + k);
        drive_src();
        run_batch("single", 4'b0001);
    endtask

    task automatic test_back_to_back();
        int c0;
        apply_reset();
        c0 = cyc;
        for (int i = 0; i < N; i++) post(i, 2);
        run_batch("rr_all", 4'b1111);
        vecs++;
        if (ack_cyc_q.size() == 4 && ack_cyc_q[0] != c0 + 2) begin
            errs++;
            $display("FAIL rr_first_ack_cycle: got %0d, want %0d", ack_cyc_q[0], c0 + 2);
        end
        for (int k = 0; k < 3 && k + 1 < ack_cyc_q.size() && k < stat_cyc_q.size(); k++) begin
            vecs++;
            if (ack_cyc_q[k+1] != stat_cyc_q[k] + 5) begin
                errs++;
                $display("FAIL rr_settle_gap[%0d]: got %0d, want %0d", k, ack_cyc_q[k+1],
                         stat_cyc_q[k] + 5);
            end
        end
        clear_logs();
        post(1, 2);
        post(3, 2);
        run_batch("rr_pair", 4'b1010);
    endtask

    task automatic test_fifo_room();
        int c0;
        clear_logs();
        wrusedw_data = 13'd8190;
        post(2, 2);
        for (int k = 0; k < 12; k++) tick();
        vecs++;
        if (ack_idx_q.size() != 0 || data_log.size() != 0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL room_hold: got acks %0d writes %0d busy %0b, want 0 0 1",
                     ack_idx_q.size(), data_log.size(), busy);
        end
        wrusedw_data = 13'd8189;
        c0 = cyc;
        run_batch("room_release", 4'b0100);
        vecs++;
        if (ack_cyc_q.size() == 1 && ack_cyc_q[0] != c0 + 1) begin
            errs++;
            $display("FAIL room_ack_cycle: got %0d, want %0d", ack_cyc_q[0], c0 + 1);
        end
        wrusedw_data = '0;
        clear_logs();
        wrfull_status = 1'b1;
        post(0, 3);
        for (int k = 0; k < 6; k++) tick();
        vecs++;
        if (ack_idx_q.size() != 0 || data_log.size() != 0) begin
            errs++;
            $display("FAIL status_full_hold: got acks %0d writes %0d, want 0 0",
                     ack_idx_q.size(), data_log.size());
        end
        wrfull_status = 1'b0;
        run_batch("status_full_release", 4'b0001);
    endtask

    task automatic test_bad_len();
        clear_logs();
        post(0, 0);
        post(1, 1473);
        post(2, 1472);
        post(3, 1);
        run_batch("bad_len", 4'b1111);
    endtask

    task automatic test_backpressure();
        int n, t;
        clear_logs();
        bubbles = 1'b1;
        post(1, 12);
        t = 0;
        while (data_log.size() < 3 && t < 200) begin
            tick();
            t++;
        end
        wrfull_data = 1'b1;
        n = data_log.size();
        for (int k = 0; k < 5; k++) tick();
        vecs++;
        if (data_log.size() != n || n < 3) begin
            errs++;
            $display("FAIL full_stall: got %0d writes (had %0d), want %0d with at least 3", data_log.size(),
                     n, n);
        end
        wrfull_data = 1'b0;
        run_batch("backpressure", 4'b0010);
        bubbles = 1'b0;
    endtask

    task automatic test_random();
        bubbles   = 1'b1;
        full_rand = 1'b1;
        used_rand = 1'b1;
        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            clear_logs();
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    int lv;
                    if (($urandom % 8) == 0) lv = ($urandom % 2) ? 0 : 1473 + int'($urandom % 575);
                    else lv = int'($urandom_range(1, 24));
                    post(i, lv);
                end
            end
            run_batch("random", mask);
        end
        bubbles      = 1'b0;
        full_rand    = 1'b0;
        used_rand    = 1'b0;
        wrfull_data  = 1'b0;
        wrusedw_data = '0;
    endtask

    task automatic test_reset_mid_frame();
        int t;
        clear_logs();
        post(0, 10);
        t = 0;
        while (data_log.size() < 2 && t < 200) begin
            tick();
            t++;
        end
        reset_n   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) src_len[i] = 0;
        drive_src();
        tick();
        check_outputs_zero("mid_frame_reset");
        reset_n     = 1'b1;
        model_last  = N - 1;
        model_count = '0;
        clear_logs();
        post(1, 3);
        run_batch("after_reset", 4'b0010);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        cyc  = 0;
        reset_n = 1'b0;
        req_valid = '0;
        req_len = '0;
        req_status = '0;
        src_valid = '0;
        src_data = '0;
        wrfull_data = 1'b0;
        wrusedw_data = '0;
        wrfull_status = 1'b0;
        bubbles = 1'b0;
        full_rand = 1'b0;
        used_rand = 1'b0;
        model_last = N - 1;
        model_count = '0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            rd[i]      = 0;
            b_len[i]   = 0;
            b_stat[i]  = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_room();
        test_bad_len();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
